// File: rtl/xor_unit_arbiter.sv
// Round-robin arbiter that shares one combinational XOR unit among NUM_REQ
// requesters: registered operands drive the unit, and its result is captured and returned.
module xor_unit_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 1,
   parameter int IDW     = $clog2(NUM_REQ)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_in1,
   input  logic [NUM_REQ*WIDTH-1:0] req_in2,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [IDW-1:0]           rsp_id,
   output logic [WIDTH-1:0]         rsp_out1,
   output logic [WIDTH-1:0]         xu_in1,
   output logic [WIDTH-1:0]         xu_in2,
   input  logic [WIDTH-1:0]         xu_out1
);

   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [IDW-1:0]   r_ptr;
   logic [IDW-1:0]   r_id;
   logic [IDW-1:0]   r_rsp_id;
   logic [WIDTH-1:0] r_op1;
   logic [WIDTH-1:0] r_op2;
   logic [WIDTH-1:0] r_rsp_out1;
   logic             r_rsp_valid;
   logic [IDW-1:0]   w_winner;
   logic [IDW-1:0]   w_scan;
   logic [IDW-1:0]   w_ptr_next;
   logic             w_any;
   logic             w_accept;
   logic [WIDTH-1:0] w_in1_arr [NUM_REQ];
   logic [WIDTH-1:0] w_in2_arr [NUM_REQ];

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign w_in1_arr[gi] = req_in1[gi*WIDTH +: WIDTH];
         assign w_in2_arr[gi] = req_in2[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // First valid requester at or after r_ptr, scanning with wrap-around.
   always_comb begin
      w_any    = 1'b0;
      w_winner = '0;
      w_scan   = r_ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!w_any && req_valid[w_scan]) begin
            w_any    = 1'b1;
            w_winner = w_scan;
         end
         w_scan = (w_scan == IDW'(NUM_REQ-1)) ? '0 : w_scan + IDW'(1);
      end
   end

   assign w_ptr_next = (w_winner == IDW'(NUM_REQ-1)) ? '0 : w_winner + IDW'(1);
   assign w_accept   = (r_state == ST_IDLE) && w_any;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (w_any)     w_state_next = ST_EXEC;
         ST_EXEC:                w_state_next = ST_RESP;
         ST_RESP: if (rsp_ready) w_state_next = ST_IDLE;
         default:                w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready = '0;
      if (w_accept) begin
         req_ready[w_winner] = 1'b1;
      end
   end

   // Operands only change on acceptance, so the shared unit sees stable inputs through EXEC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr       <= '0;
         r_id        <= '0;
         r_op1       <= '0;
         r_op2       <= '0;
         r_rsp_id    <= '0;
         r_rsp_out1  <= '0;
         r_rsp_valid <= 1'b0;
      end else begin
         if (w_accept) begin
            r_op1 <= w_in1_arr[w_winner];
            r_op2 <= w_in2_arr[w_winner];
            r_id  <= w_winner;
            r_ptr <= w_ptr_next;
         end
         if (r_state == ST_EXEC) begin
            r_rsp_out1  <= xu_out1;
            r_rsp_id    <= r_id;
            r_rsp_valid <= 1'b1;
         end else if (r_state == ST_RESP && rsp_ready) begin
            r_rsp_valid <= 1'b0;
         end
      end
   end

   assign xu_in1    = r_op1;
   assign xu_in2    = r_op2;
   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_out1  = r_rsp_out1;

endmodule

// File: tb/tb_xor_unit_arbiter.sv
// Randomised bench for xor_unit_arbiter: a transaction-level round-robin model
// feeds a scoreboard queue that an independent monitor drains on responses.
module tb_xor_unit_arbiter;

   localparam int N   = 4;
   localparam int W   = 8;
   localparam int IDW = 2;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_in1;
   logic [N*W-1:0] req_in2;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [IDW-1:0] rsp_id;
   logic [W-1:0]   rsp_out1;
   logic [W-1:0]   xu_in1;
   logic [W-1:0]   xu_in2;
   logic [W-1:0]   xu_out1;

   xor_unit_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_in1   (req_in1),
      .req_in2   (req_in2),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_out1  (rsp_out1),
      .xu_in1    (xu_in1),
      .xu_in2    (xu_in2),
      .xu_out1   (xu_out1)
   );

   // Stand-in for the shared combinational XOR unit.
   assign xu_out1 = xu_in1 ^ xu_in2;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         id;
      logic [W-1:0] a;
      logic [W-1:0] b;
      int         acc;
   } txn_t;

   txn_t exp_q[$];
   int   n_tests  = 0;
   int   n_fail   = 0;
   int   accepts  = 0;
   int   done     = 0;
   int   exp_ptr  = 0;
   int   granted  = -1;
   logic [W-1:0] op_a [N];
   logic [W-1:0] op_b [N];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic rand_ops();
      for (int i = 0; i < N; i++) begin
         op_a[i] = W'($urandom);
         op_b[i] = W'($urandom);
      end
   endtask

   // One cycle of stimulus: retire last grant, withdraw/raise requests, then
   // predict the grant from the round-robin rule (one transaction in flight).
   task automatic step(input logic [N-1:0] raise, input logic [N-1:0] drop, input logic rr);
      logic [N-1:0] exp_rdy;
      int w;
      @(negedge clk);
      if (granted >= 0) begin
         req_valid[granted] = 1'b0;
         granted = -1;
      end
      for (int i = 0; i < N; i++) begin
         if (drop[i]) req_valid[i] = 1'b0;
         if (raise[i] && !req_valid[i]) begin
            req_valid[i]        = 1'b1;
            req_in1[i*W +: W]   = op_a[i];
            req_in2[i*W +: W]   = op_b[i];
         end
      end
      rsp_ready = rr;
      #1;
      w = -1;
      if (accepts == done) begin
         for (int k = 0; k < N; k++) begin
            int idx;
            idx = (exp_ptr + k) % N;
            if (w < 0 && req_valid[idx]) w = idx;
         end
      end
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      if (w >= 0) begin
         exp_q.push_back('{id: w, a: req_in1[w*W +: W], b: req_in2[w*W +: W], acc: cyc + 1});
         exp_ptr = (w + 1) % N;
         accepts++;
         granted = w;
      end
   endtask

   task automatic drain(input int n);
      repeat (n) step('0, '0, 1'b1);
   endtask

   // Monitor: pops the scoreboard when a response appears and checks it.
   initial begin
      txn_t cur;
      bit   in_rsp;
      in_rsp = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            exp_q.delete();
            done   = accepts;
            in_rsp = 1'b0;
         end else begin
            if (!in_rsp && exp_q.size() > 0 && cyc == exp_q[0].acc) begin
               chk("xu_in1", 64'(xu_in1), 64'(exp_q[0].a));
               chk("xu_in2", 64'(xu_in2), 64'(exp_q[0].b));
            end
            if (rsp_valid) begin
               if (!in_rsp) begin
                  if (exp_q.size() == 0) begin
                     chk("rsp_valid_spurious", 64'(rsp_valid), 64'(0));
                  end else begin
                     cur    = exp_q.pop_front();
                     in_rsp = 1'b1;
                     chk("rsp_latency", 64'(cyc), 64'(cur.acc + 1));
                  end
               end
               if (in_rsp) begin
                  chk("rsp_id", 64'(rsp_id), 64'(cur.id));
                  chk("rsp_out1", 64'(rsp_out1), 64'(cur.a ^ cur.b));
                  if (rsp_ready) begin
                     $display("[TB] rsp id=%0d a=%02h b=%02h out=%02h cycle=%0d",
                              rsp_id, cur.a, cur.b, rsp_out1, cyc);
                     in_rsp = 1'b0;
                     done++;
                  end
               end
            end else if (in_rsp) begin
               chk("rsp_valid_dropped", 64'(rsp_valid), 64'(1));
            end else if (exp_q.size() > 0 && cyc >= exp_q[0].acc + 1) begin
               chk("rsp_valid_missing", 64'(rsp_valid), 64'(1));
            end
         end
      end
   end

   initial begin
      logic [N-1:0] rm;
      logic [N-1:0] dm;
      rst_n     = 1'b0;
      req_valid = '0;
      req_in1   = '0;
      req_in2   = '0;
      rsp_ready = 1'b0;
      #3;
      chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("reset_rsp_id",    64'(rsp_id),    64'(0));
      chk("reset_rsp_out1",  64'(rsp_out1),  64'(0));
      chk("reset_xu_in1",    64'(xu_in1),    64'(0));
      chk("reset_xu_in2",    64'(xu_in2),    64'(0));
      chk("reset_req_ready", 64'(req_ready), 64'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Single request with wide operands: A5 ^ 0F = AA.
      rand_ops();
      op_a[0] = 8'hA5;
      op_b[0] = 8'h0F;
      step(4'b0001, '0, 1'b1);
      drain(4);

      // All requesters contending with fixed operand pairs.
      op_a[0] = 8'h01; op_b[0] = 8'h00;
      op_a[1] = 8'h01; op_b[1] = 8'h01;
      op_a[2] = 8'h00; op_b[2] = 8'h01;
      op_a[3] = 8'h00; op_b[3] = 8'h00;
      step(4'b1111, '0, 1'b1);
      drain(14);

      // Wrap: grant 2, then 0101 must go to 0 before 2.
      rand_ops();
      step(4'b0100, '0, 1'b1);
      drain(4);
      rand_ops();
      step(4'b0101, '0, 1'b1);
      drain(8);

      // Backpressure with other requesters waiting.
      rand_ops();
      step(4'b0010, '0, 1'b1);
      repeat (8) step(4'b1101, '0, 1'b0);
      drain(12);

      // Reset while the accepted transaction is in EXEC.
      rand_ops();
      step(4'b1000, '0, 1'b1);
      @(negedge clk);
      req_valid = '0;
      granted   = -1;
      rst_n     = 1'b0;
      #1;
      chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("midrst_rsp_id",    64'(rsp_id),    64'(0));
      chk("midrst_rsp_out1",  64'(rsp_out1),  64'(0));
      chk("midrst_xu_in1",    64'(xu_in1),    64'(0));
      chk("midrst_xu_in2",    64'(xu_in2),    64'(0));
      chk("midrst_req_ready", 64'(req_ready), 64'(0));
      exp_ptr = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      drain(4);
      rand_ops();
      step(4'b1111, '0, 1'b1);
      drain(20);

      // Randomised traffic with withdrawals and consumer stalls.
      for (int t = 0; t < 1500; t++) begin
         rand_ops();
         rm = N'($urandom & $urandom);
         dm = N'($urandom & $urandom & $urandom & $urandom);
         step(rm, dm, ($urandom % 4) != 0);
      end
      for (int i = 0; i < N; i++) req_valid[i] = 1'b0;
      granted = -1;
      drain(10);
      chk("queue_drained", 64'(exp_q.size()), 64'(0));
      chk("accepts_vs_responses", 64'(done), 64'(accepts));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
